mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width of the shared data memory (4096 words).
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0 / req1  input  1 each  access request from requester 0 / requester 1.
REQ-006 we0 / we1  input  1 each  1 = write, 0 = read; qualified by reqN.
REQ-007 addr0 / addr1  input  ADDR_W each  word address; qualified by reqN.
REQ-008 wdata0 / wdata1  input  DATA_W each  write data; qualified by reqN and weN.
REQ-009 gnt0 / gnt1  output  1 each  one-cycle grant pulse; request has been accepted.
REQ-010 done0 / done1  output  1 each  one-cycle completion pulse; for reads, rdata valid in the same cycle.
REQ-011 rdata  output  DATA_W  read data returned to the requester whose doneN is high.
REQ-012 busy  output  1  high while state is not IDLE.
REQ-013 mem_addr  output  ADDR_W  registered address to the memory.
REQ-014 mem_we  output  1  registered write enable to the memory (memory writes on rising clk edge).
REQ-015 mem_wdata  output  DATA_W  registered write data to the memory.
REQ-016 mem_rdata  input  DATA_W  memory read data; valid after the falling edge within the cycle mem_addr is presented with mem_we=0.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP; encoding from the shared package.
REQ-018 IDLE: when req0|req1, select a winner, register its addr/we/wdata onto mem_addr/mem_we/mem_wdata, register the winner index, go to ACCESS; otherwise stay in IDLE.
REQ-019 ACCESS: gntN high for the winner for exactly this cycle; the memory performs the operation; for reads, capture mem_rdata into rdata at the closing edge; go to RESP.
REQ-020 RESP: mem_we low; doneN high for the winner for exactly this cycle; go to IDLE.
REQ-021 Latency: request sampled at edge T, gnt in cycle T+1, done in cycle T+2; one transaction per 3 cycles maximum.
REQ-022 mem_we is high only during ACCESS, so exactly one memory write occurs per write transaction, at the edge ending ACCESS.
REQ-023 Requesters hold reqN/weN/addrN/wdataN stable until gntN is seen; inputs are ignored outside IDLE; a req still high in the cycle after done is treated as a new request.
REQ-024 rdata holds its last captured value between reads; it is not updated by writes.
REQ-025 gnt0 and gnt1 are never high together; likewise done0 and done1.
REQ-026 Address wrap: none; addresses are used as given, full ADDR_W range valid.

Reset
REQ-027 When rst is sampled high: state=IDLE, gnt0=gnt1=done0=done1=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, round-robin pointer so requester 0 wins the next tie.
REQ-028 rst in the middle of a transaction aborts it: no gnt/done issued afterward; a write whose mem_we was already high at the reset edge completes in memory.

Configuration
REQ-029 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests the requester not granted last wins; the last-winner pointer updates on every grant.
REQ-030 MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins ties; no pointer register exists.

Structure
REQ-031 Shared package mem_arb_pkg holds ADDR_W/DATA_W defaults and the FSM state type/encoding (IDLE, ACCESS, RESP).
REQ-032 One sub-module, mem_arb_pick: combinational winner select from req0, req1 and the last-winner bit, containing the macro-dependent logic.

Verification
REQ-033 req0 read addr 0x001 alone, memory word 0x0002 -> gnt0 in cycle T+1, done0 in T+2 with rdata=0x0002.
REQ-034 req1 write addr 0x008 data 0xBEEF, then req1 read 0x008 -> exactly one mem_we pulse; second done1 with rdata=0xBEEF.
REQ-035 req0 and req1 held high continuously (round-robin on) -> grants alternate 0,1,0,1; with macro off -> gnt0 every transaction, gnt1 never.
REQ-036 req0 read of 0xFFF after write 0x1234 to 0xFFF -> rdata=0x1234; no aliasing onto 0x000.
REQ-037 rst asserted during ACCESS of a read -> no done0; next cycle state IDLE, busy=0, all outputs at reset values.
REQ-038 Request arriving while busy -> not granted until the following IDLE; rdata unchanged by intervening writes.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths and FSM state encoding.
package mem_arb_pkg;

  localparam int MEM_ARB_ADDR_W = 12;
  localparam int MEM_ARB_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between two requesters.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on ties; otherwise requester 0 has fixed priority.
module mem_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_win,
  output logic valid,
  output logic win
);

  assign valid = req0 | req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie the requester that was not granted last wins.
  always_comb begin
    if (req0 && req1) win = ~last_win;
    else              win = req1;
  end
`else
  logic unused_last_win;
  assign unused_last_win = last_win;
  assign win = ~req0;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory: IDLE -> ACCESS -> RESP per transaction.
// Optional macro MEM_ARB_ROUND_ROBIN_EN enables round-robin tie-breaking (fixed priority otherwise).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ARB_ADDR_W,
  parameter int DATA_W = MEM_ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester raises reqN with stable we/addr/wdata and holds them until gntN;
  // requests are only sampled in IDLE, and doneN (with rdata for reads) follows gntN by one cycle.

  arb_state_t state, state_nxt;
  logic       win_q;
  logic       last_win;
  logic       pick_valid, pick_win;

  mem_arb_pick u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_win (last_win),
    .valid    (pick_valid),
    .win      (pick_win)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)                               last_win <= 1'b1;
    else if (state == IDLE && pick_valid) last_win <= pick_win;
  end
`else
  assign last_win = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q     <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            win_q     <= pick_win;
            mem_addr  <= pick_win ? addr1  : addr0;
            mem_we    <= pick_win ? we1    : we0;
            mem_wdata <= pick_win ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          // The memory write (if any) lands on this edge; reads capture here.
          mem_we <= 1'b0;
          if (!mem_we) rdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign gnt0      = (state == ACCESS) && !win_q;
  assign gnt1      = (state == ACCESS) &&  win_q;
  assign done0     = (state == RESP)   && !win_q;
  assign done1     = (state == RESP)   &&  win_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
